// File: rtl/bc_pkg.sv
// Shared constants and types for the breadcrumb SPI link.
package bc_pkg;

  localparam int unsigned BC_WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } bc_spi_state_t;

endpackage

// File: rtl/bc_sync_edge.sv
// Pin synchroniser plus history flop; rise/fall are registered one-cycle strobes.
module bc_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;

  // level doubles as the history flop, so strobes and level stay aligned
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      level  <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~level;
      fall   <= ~sync_q[SYNC_STAGES-1] & level;
    end
  end

endmodule

// File: rtl/bc_spi_link.sv
// SPI mode-0 slave between the Avoidance MCU and the breadcrumb buffer,
// oversampled in the clk domain.
module bc_spi_link
  import bc_pkg::*;
#(
  parameter int unsigned WORD_W      = BC_WORD_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [WORD_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_rdy,
  input  logic [WORD_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_rdy,
  output logic              rx_overrun,
  output logic              tx_underrun,
  output logic              short_frame
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  bc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .rst(rst), .din(spi_sck),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  bc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .din(spi_cs_n),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  bc_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(spi_mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_edges;
  assign unused_edges = sck_lvl ^ cs_lvl ^ mosi_rise ^ mosi_fall;

  bc_spi_state_t     state_q;
  logic [WORD_W-1:0] tx_shift;
  logic [WORD_W-1:0] rx_shift;
  logic [WORD_W-1:0] rx_shift_nxt;
  logic [CNT_W-1:0]  bit_cnt;

  assign rx_shift_nxt = {rx_shift[WORD_W-2:0], mosi_lvl};

  // The pop/underrun strobes must coincide with the LOAD cycle that samples tx_valid
  assign tx_rdy      = (state_q == LOAD) & tx_valid;
  assign tx_underrun = (state_q == LOAD) & ~tx_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      tx_shift    <= '0;
      rx_shift    <= '0;
      bit_cnt     <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      spi_miso    <= 1'b0;
      rx_overrun  <= 1'b0;
      short_frame <= 1'b0;
    end else begin
      rx_overrun  <= 1'b0;
      short_frame <= 1'b0;
      if (rx_valid && rx_rdy) rx_valid <= 1'b0;

      case (state_q)
        IDLE: begin
          spi_miso <= 1'b0;
          if (cs_fall) state_q <= LOAD;
        end

        LOAD: begin
          tx_shift <= tx_valid ? tx_data : '0;
          spi_miso <= tx_valid & tx_data[WORD_W-1];
          rx_shift <= '0;
          bit_cnt  <= '0;
          state_q  <= SHIFT;
        end

        SHIFT: begin
          if (cs_rise) begin
            short_frame <= 1'b1;
            rx_shift    <= '0;
            spi_miso    <= 1'b0;
            state_q     <= IDLE;
          end else if (sck_rise) begin
            rx_shift <= rx_shift_nxt;
            bit_cnt  <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(WORD_W - 1)) begin
              state_q  <= DONE;
              spi_miso <= 1'b0;
              // word commit: a pending word being accepted this cycle frees the slot
              if (!rx_valid || rx_rdy) begin
                rx_data  <= rx_shift_nxt;
                rx_valid <= 1'b1;
              end else begin
                rx_overrun <= 1'b1;
              end
            end
          end else if (sck_fall && (bit_cnt != '0)) begin
            tx_shift <= tx_shift << 1;
            spi_miso <= tx_shift[WORD_W-2];
          end
        end

        DONE: begin
          spi_miso <= 1'b0;
          if (cs_fall)      state_q <= LOAD;
          else if (cs_rise) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bc_spi_link.sv
// Directed + randomized bench for bc_spi_link with an MCU-side frame model.
module tb_bc_spi_link;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_cs_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_rdy = 1'b1;
  logic [15:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_rdy;
  logic        rx_overrun;
  logic        tx_underrun;
  logic        short_frame;

  int total = 0;
  int bad   = 0;

  int n_pop = 0, n_under = 0, n_short = 0, n_over = 0;
  int e_pop = 0, e_under = 0, e_short = 0, e_over = 0;
  logic [15:0] acc_q[$];
  logic [15:0] exp_acc[$];

  bc_spi_link dut (
    .clk(clk), .rst(rst),
    .spi_sck(spi_sck), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_rdy(rx_rdy),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_rdy(tx_rdy),
    .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .short_frame(short_frame)
  );

  always #5 clk = ~clk;

  // Observe buffer-side strobes and accepted words
  always @(negedge clk) begin
    if (rst) begin
      if (tx_rdy)              n_pop   <= n_pop + 1;
      if (tx_underrun)         n_under <= n_under + 1;
      if (short_frame)         n_short <= n_short + 1;
      if (rx_overrun)          n_over  <= n_over + 1;
      if (rx_valid && rx_rdy)  acc_q.push_back(rx_data);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // MCU side: mode 0, sck = clk/8, MSB first; returns MISO bits sampled at each rise
  task automatic spi_bits(input logic [15:0] w, input int nbits, output logic [31:0] rd);
    rd = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 16) ? w[15-i] : 1'($urandom);
      wait_clk(4);
      rd = {rd[30:0], spi_miso};
      spi_sck = 1'b1;
      wait_clk(4);
      spi_sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [15:0] w, input int nbits, output logic [31:0] rd);
    @(negedge clk);
    spi_cs_n = 1'b0;
    wait_clk(8);
    spi_bits(w, nbits, rd);
    wait_clk(4);
    spi_cs_n = 1'b1;
    wait_clk(8);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_pop"},   32'(n_pop),   32'(e_pop));
    chk({tag, "_under"}, 32'(n_under), 32'(e_under));
    chk({tag, "_short"}, 32'(n_short), 32'(e_short));
    chk({tag, "_over"},  32'(n_over),  32'(e_over));
    chk({tag, "_nacc"},  32'(acc_q.size()), 32'(exp_acc.size()));
  endtask

  initial begin
    logic [31:0] rd;
    logic [15:0] w, td;
    logic        tv;

    // Reset state
    wait_clk(3);
    chk("reset_outs", {25'b0, spi_miso, rx_valid, tx_rdy, rx_overrun, tx_underrun, short_frame, 1'b0}, 32'h0);
    chk("reset_rx_data", 32'(rx_data), 32'h0);
    rst = 1'b1;
    wait_clk(8);

    // Normal frame
    tx_valid = 1'b1; tx_data = 16'hA5C3;
    frame(16'h1234, 16, rd);
    e_pop++; exp_acc.push_back(16'h1234);
    chk("norm_miso", rd, 32'h0000_A5C3);
    chk("norm_rx", (acc_q.size() > 0) ? 32'(acc_q[$]) : 32'hDEAD, 32'h1234);
    chk_counts("norm");

    // Backpressure / overrun
    rx_rdy = 1'b0;
    frame(16'h1111, 16, rd);
    e_pop++;
    chk("bp_valid1", 32'(rx_valid), 32'h1);
    chk("bp_data1", 32'(rx_data), 32'h1111);
    frame(16'h2222, 16, rd);
    e_pop++; e_over++;
    chk("bp_data2", 32'(rx_data), 32'h1111);
    chk_counts("bp");
    rx_rdy = 1'b1;
    exp_acc.push_back(16'h1111);
    wait_clk(2);
    chk("bp_clear", 32'(rx_valid), 32'h0);
    chk("bp_acc", (acc_q.size() > 0) ? 32'(acc_q[$]) : 32'hDEAD, 32'h1111);

    // Underrun
    tx_valid = 1'b0; tx_data = 16'hFFFF;
    frame(16'h5A5A, 16, rd);
    e_under++; exp_acc.push_back(16'h5A5A);
    chk("under_miso", rd, 32'h0);
    chk_counts("under");

    // Short frame, then a full one
    tx_valid = 1'b1; tx_data = 16'h0F0F;
    frame(16'h9999, 9, rd);
    e_pop++; e_short++;
    chk("short_valid", 32'(rx_valid), 32'h0);
    chk_counts("short");
    tx_data = 16'h7E81;
    frame(16'hBEEF, 16, rd);
    e_pop++; exp_acc.push_back(16'hBEEF);
    chk("after_short_miso", rd, 32'h0000_7E81);
    chk("after_short_rx", (acc_q.size() > 0) ? 32'(acc_q[$]) : 32'hDEAD, 32'hBEEF);

    // Long frame: 4 extra bits must be ignored and MISO must be 0 for them
    tx_data = 16'h3C96;
    frame(16'hCAFE, 20, rd);
    e_pop++; exp_acc.push_back(16'hCAFE);
    chk("long_miso", rd >> 4, 32'h0000_3C96);
    chk("long_extra", 32'(rd[3:0]), 32'h0);
    chk("long_rx", (acc_q.size() > 0) ? 32'(acc_q[$]) : 32'hDEAD, 32'hCAFE);
    chk_counts("long");

    // Reset mid-frame after 7 bits with cs_n held low
    tx_data = 16'h1357;
    @(negedge clk);
    spi_cs_n = 1'b0;
    wait_clk(8);
    spi_bits(16'hABCD, 7, rd);
    wait_clk(2);
    e_pop++;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", {26'b0, spi_miso, rx_valid, tx_rdy, rx_overrun, tx_underrun, short_frame}, 32'h0);
    chk("rst_mid_data", 32'(rx_data), 32'h0);
    wait_clk(2);
    rst = 1'b1;
    wait_clk(4);
    spi_bits(16'hFFFF, 16, rd);
    wait_clk(4);
    spi_cs_n = 1'b1;
    wait_clk(8);
    chk_counts("ghost");
    tx_data = 16'h2468;
    frame(16'h0F0F, 16, rd);
    e_pop++; exp_acc.push_back(16'h0F0F);
    chk("post_rst_miso", rd, 32'h0000_2468);
    chk("post_rst_rx", (acc_q.size() > 0) ? 32'(acc_q[$]) : 32'hDEAD, 32'h0F0F);

    // Randomized frames
    for (int i = 0; i < 8; i++) begin
      tv = 1'($urandom_range(0, 1));
      td = 16'($urandom);
      w  = 16'($urandom);
      tx_valid = tv; tx_data = td;
      frame(w, 16, rd);
      if (tv) e_pop++; else e_under++;
      exp_acc.push_back(w);
      chk($sformatf("rnd%0d_miso", i), rd, tv ? 32'(td) : 32'h0);
    end
    chk_counts("rnd");

    for (int i = 0; i < exp_acc.size(); i++)
      chk($sformatf("acc%0d", i), (i < acc_q.size()) ? 32'(acc_q[i]) : 32'hDEAD_BEEF, 32'(exp_acc[i]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
